// File: rtl/reg_bank_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register-bank write arbiter:
//   - arb_state_e : arbiter FSM states (IDLE / GRANT / HOLD)
//   - DEF_*       : default parameter values
//   - rot_right   : rotates a requester mask so the current priority holder
//                   lands on bit 0
// Optional feature macro used by the files that import this package:
// ARB_LOCK_EN (lock / HOLD support).
// -----------------------------------------------------------------------------
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 8;
    localparam int DEF_AW   = 2;

    // Upper bound on NREQ; masks are carried at this width inside rot_right.
    localparam int MAX_NREQ = 8;

    // Rotate the low n bits of v right by amt (amt < n). Bits at or above n
    // are returned as 0. After rotation, bit k corresponds to requester
    // (amt + k) mod n.
    function automatic logic [MAX_NREQ-1:0] rot_right(input logic [MAX_NREQ-1:0] v,
                                                      input int amt,
                                                      input int n);
        logic [MAX_NREQ-1:0] r;
        int src;
        r = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (i < n) begin
                src = i + amt;
                if (src >= n) begin
                    src = src - n;
                end
                r[i] = v[src[2:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_bank_write_arbiter_if
// Bundles the requester side and bank side of the write arbiter.
//   REQ   [NREQ]      per-requester write request (level)
//   ADDR  [NREQ*AW]   per-requester target address, requester i at [i*AW +: AW]
//   WDATA [NREQ*DW]   per-requester write data,     requester i at [i*DW +: DW]
//   LOCK  [NREQ]      per-requester lock request (only with ARB_LOCK_EN)
//   GNT   [NREQ]      one-hot registered grant pulse
//   E_OUT [2^AW]      one-hot registered bank enable
//   D_OUT [DW]        registered bank write data
//   BUSY              high while the arbiter is locked in HOLD
// Modports: master = requesters/bank (drives requests), slave = arbiter.
// Optional feature macro: ARB_LOCK_EN.
// -----------------------------------------------------------------------------
interface reg_bank_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
);
    logic [NREQ-1:0]      REQ;
    logic [NREQ*AW-1:0]   ADDR;
    logic [NREQ*DW-1:0]   WDATA;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]      LOCK;
`endif
    logic [NREQ-1:0]      GNT;
    logic [(1<<AW)-1:0]   E_OUT;
    logic [DW-1:0]        D_OUT;
    logic                 BUSY;

    modport master (
        output REQ, ADDR, WDATA,
`ifdef ARB_LOCK_EN
        output LOCK,
`endif
        input  GNT, E_OUT, D_OUT, BUSY
    );

    modport slave (
        input  REQ, ADDR, WDATA,
`ifdef ARB_LOCK_EN
        input  LOCK,
`endif
        output GNT, E_OUT, D_OUT, BUSY
    );

endinterface

// File: rtl/reg_bank_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req_i  [NREQ]  raw requests
//   ptr_i  [PW]    requester with top priority this cycle
//   mask_i [NREQ]  requesters allowed to compete
//   gnt_o  [NREQ]  one-hot winner (0 when nothing is eligible)
//   vld_o          a winner exists
// -----------------------------------------------------------------------------
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    input  logic [NREQ-1:0] mask_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            vld_o
);

    logic [MAX_NREQ-1:0] cand;
    logic [MAX_NREQ-1:0] rot;
    int                  idx;

    always_comb begin
        cand             = '0;
        cand[NREQ-1:0]   = req_i & mask_i;
        // Rotate so bit 0 is the pointer position; the lowest set bit is then
        // the first eligible requester in scan order ptr, ptr+1, ...
        rot   = rot_right(cand, int'(ptr_i), NREQ);
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!vld_o && rot[k]) begin
                idx = k + int'(ptr_i);
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                gnt_o[idx[PW-1:0]] = 1'b1;
                vld_o              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_write_arbiter
// Round-robin arbiter sharing the write port of a 2^AW x DW register bank
// between NREQ requesters. Each edge the first requesting index at or after
// PTR (wrapping) wins; its grant, decoded bank enable and write data are
// registered and valid for exactly the following cycle.
//   CLK   system clock, rising edge
//   RST_N asynchronous active-low reset
//   bus   reg_bank_write_arbiter_if.slave (REQ/ADDR/WDATA[/LOCK] in,
//         GNT/E_OUT/D_OUT/BUSY out)
// Optional feature macro: ARB_LOCK_EN -- a winner with LOCK set keeps the
// port (HOLD state, BUSY high, PTR frozen) until it drops LOCK or REQ.
// Without it BUSY is tied low and HOLD is never entered.
// -----------------------------------------------------------------------------
module reg_bank_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) (
    input logic                    CLK,
    input logic                    RST_N,
    reg_bank_write_arbiter_if.slave bus
);

    localparam int PW   = $clog2(NREQ);
    localparam int NREG = 1 << AW;

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    ptr_q,   ptr_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [NREG-1:0]  e_q,     e_d;
    logic [DW-1:0]    d_q,     d_d;

    logic [NREQ-1:0]  mask;
    logic [NREQ-1:0]  pick_gnt;
    logic             pick_vld;
    logic [PW-1:0]    win_idx;
    logic [AW-1:0]    win_addr;
    logic [DW-1:0]    win_data;
    logic             hold_keep;

`ifdef ARB_LOCK_EN
    logic [PW-1:0]    hold_idx_q, hold_idx_d;
`endif

    // Lock masking: while HOLD persists only the lock owner may compete.
    always_comb begin
        mask      = '1;
        hold_keep = 1'b0;
`ifdef ARB_LOCK_EN
        if (state_q == HOLD && bus.LOCK[hold_idx_q] && bus.REQ[hold_idx_q]) begin
            hold_keep            = 1'b1;
            mask                 = '0;
            mask[hold_idx_q]     = 1'b1;
        end
`endif
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i  (bus.REQ),
        .ptr_i  (ptr_q),
        .mask_i (mask),
        .gnt_o  (pick_gnt),
        .vld_o  (pick_vld)
    );

    // Winner index, address and data mux.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                win_idx  = PW'(i);
                win_addr = bus.ADDR[i*AW +: AW];
                win_data = bus.WDATA[i*DW +: DW];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        e_d     = '0;
        d_d     = d_q;
`ifdef ARB_LOCK_EN
        hold_idx_d = hold_idx_q;
`endif
        if (pick_vld) begin
            gnt_d          = pick_gnt;
            e_d[win_addr]  = 1'b1;
            d_d            = win_data;
            // PTR is frozen for grants made inside a persisting lock; every
            // other grant (including the one that enters HOLD) advances it.
            if (!hold_keep) begin
                ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
            end
            state_d = GRANT;
`ifdef ARB_LOCK_EN
            if (bus.LOCK[win_idx]) begin
                state_d    = HOLD;
                hold_idx_d = win_idx;
            end
`endif
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            e_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            e_q     <= e_d;
            d_q     <= d_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_idx_q <= '0;
        end else begin
            hold_idx_q <= hold_idx_d;
        end
    end

    assign bus.BUSY = (state_q == HOLD);
`else
    assign bus.BUSY = 1'b0;
`endif

    assign bus.GNT   = gnt_q;
    assign bus.E_OUT = e_q;
    assign bus.D_OUT = d_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_write_arbiter
// Directed bench for reg_bank_write_arbiter (NREQ=4, DW=8, AW=2) with a
// behavioural register bank (async preset to 8'hFF) fed by E_OUT/D_OUT.
// -----------------------------------------------------------------------------
module tb_reg_bank_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 2;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    reg_bank_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    reg_bank_write_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Register bank model: enable-gated D registers with active-low preset.
    logic [DW-1:0] bank [4];
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) bank[i] <= 8'hFF;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.E_OUT[i]) bank[i] <= bus.D_OUT;
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] e,
                              input logic [7:0] d, input logic b);
        check({tag, " GNT"},   32'(bus.GNT),   32'(g));
        check({tag, " E_OUT"}, 32'(bus.E_OUT), 32'(e));
        check({tag, " D_OUT"}, 32'(bus.D_OUT), 32'(d));
        check({tag, " BUSY"},  32'(bus.BUSY),  32'(b));
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  e;
        logic [7:0]  d;
    } vec_t;

    vec_t vt [16];

    initial begin
        // Starts right after a reset, so PTR=0 and D_OUT=0.
        vt[0]  = '{4'b1001, 8'h00, 32'h0000_0001, 4'b0001, 4'b0001, 8'h01};
        vt[1]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 8'h01};
        vt[2]  = '{4'b0100, 8'h10, 32'h003C_0000, 4'b0100, 4'b0010, 8'h3C};
        vt[3]  = '{4'b0100, 8'h10, 32'h003C_0000, 4'b0100, 4'b0010, 8'h3C};
        vt[4]  = '{4'b0100, 8'h10, 32'h003C_0000, 4'b0100, 4'b0010, 8'h3C};
        vt[5]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 8'h3C};
        // PTR=3 here: wrap to 0, then skip 1 to reach 2.
        vt[6]  = '{4'b0101, 8'h30, 32'h0066_0055, 4'b0001, 4'b0001, 8'h55};
        vt[7]  = '{4'b0101, 8'h30, 32'h0066_0055, 4'b0100, 4'b1000, 8'h66};
        vt[8]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 8'h66};
        vt[9]  = '{4'b1000, 8'h80, 32'h7700_0000, 4'b1000, 4'b0100, 8'h77};
        // PTR=0: collision on address 3.
        vt[10] = '{4'b0011, 8'h0F, 32'h0000_2211, 4'b0001, 4'b1000, 8'h11};
        vt[11] = '{4'b0010, 8'h0F, 32'h0000_2211, 4'b0010, 4'b1000, 8'h22};
        // Requester 3 loses, then withdraws before being granted.
        vt[12] = '{4'b1100, 8'h40, 32'hAA99_0000, 4'b0100, 4'b0001, 8'h99};
        vt[13] = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 8'h99};
        vt[14] = '{4'b0001, 8'h02, 32'h0000_005A, 4'b0001, 4'b0100, 8'h5A};
        vt[15] = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 8'h5A};

        RST_N     = 1'b1;
        bus.REQ   = '0;
        bus.ADDR  = '0;
        bus.WDATA = '0;
`ifdef ARB_LOCK_EN
        bus.LOCK  = '0;
`endif
        #2 RST_N = 1'b0;
        #1;
        check_outs("reset", 4'b0000, 4'b0000, 8'h00, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Fairness from reset: all four request continuously.
        bus.ADDR  = 8'hE4;            // addr_i = i
        bus.WDATA = 32'h0403_0201;    // wdata_i = i+1
        bus.REQ   = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK);
            #1;
            check_outs($sformatf("fair%0d", c), 4'(1 << (c % 4)), 4'(1 << (c % 4)),
                       8'((c % 4) + 1), 1'b0);
        end

        // Reset in the middle of a grant cycle.
        bus.REQ   = 4'b0001;
        bus.ADDR  = 8'h02;
        bus.WDATA = 32'h0000_00A5;
        @(posedge CLK);
        #1;
        check_outs("pre-rst", 4'b0001, 4'b0100, 8'hA5, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        check("async rst GNT",   32'(bus.GNT),   32'h0);
        check("async rst E_OUT", 32'(bus.E_OUT), 32'h0);
        check("async rst D_OUT", 32'(bus.D_OUT), 32'h0);
        check("dropped write bank2", 32'(bank[2]), 32'hFF);
        bus.REQ = '0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Table-driven vectors (vt[0] confirms PTR=0 after reset).
        for (int i = 0; i < 16; i++) begin
            bus.REQ   = vt[i].req;
            bus.ADDR  = vt[i].addr;
            bus.WDATA = vt[i].wdata;
            @(posedge CLK);
            #1;
            check_outs($sformatf("vec%0d", i), vt[i].gnt, vt[i].e, vt[i].d, 1'b0);
            if (i == 11) check("collision first write", 32'(bank[3]), 32'h11);
        end
        check("bank0", 32'(bank[0]), 32'h99);
        check("bank1", 32'(bank[1]), 32'h3C);
        check("bank2", 32'(bank[2]), 32'h5A);
        check("bank3 collision final", 32'(bank[3]), 32'h22);

`ifdef ARB_LOCK_EN
        // PTR=1 here. Requester 1 locks the port for four edges.
        bus.REQ   = 4'b1011;
        bus.ADDR  = 8'hC4;            // a0=0, a1=1, a3=3
        bus.WDATA = 32'hD300_B1A0;
        bus.LOCK  = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK);
            #1;
            check_outs($sformatf("lock%0d", c), 4'b0010, 4'b0010, 8'hB1, 1'b1);
        end
        bus.LOCK = 4'b0000;
        @(posedge CLK);
        #1;
        check_outs("unlock", 4'b1000, 4'b1000, 8'hD3, 1'b0);
        bus.REQ = '0;
        @(posedge CLK);
        #1;
        check_outs("lock idle", 4'b0000, 4'b0000, 8'hD3, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
